cpu_req_master: RTL and testbench

- CPU-side initiator for the cache controller's request/ready interface.
- Buffers host commands (read/write, address, data) in a command FIFO and issues them one at a time on cpu_re/cpu_we/cpu_addr/cpu_wdata.
- Waits for the single-cycle ready pulse, then captures cpu_rdata into a response FIFO.
- Watchdog-times-out stuck transactions; used as the processor-side driver in system benches and as the traffic front end.

---
 rtl/cpu_req_master_if.sv | 43 ++++
 rtl/cpu_req_master.sv | 175 +++++++++++++++++
 tb/tb_cpu_req_master.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_req_master_if.sv
// Host command/response channels and the cache-controller request bus of cpu_req_master.
// The master modport is the cpu_req_master side; slave is the host/controller side.
interface cpu_req_master_if #(
   parameter int ADDRESSLENGTH = 16,
   parameter int DATALENGTH    = 32
);
   logic                     cmd_valid;
   logic                     cmd_ready;
   logic                     cmd_write;
   logic [ADDRESSLENGTH-1:0] cmd_addr;
   logic [DATALENGTH-1:0]    cmd_wdata;

   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [DATALENGTH-1:0]    rsp_rdata;
   logic                     rsp_write;
   logic                     rsp_error;

   logic                     cpu_re;
   logic                     cpu_we;
   logic [ADDRESSLENGTH-1:0] cpu_addr;
   logic [DATALENGTH-1:0]    cpu_wdata;
   logic [DATALENGTH-1:0]    cpu_rdata;
   logic                     ready;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      output cmd_ready,
      output rsp_valid, rsp_rdata, rsp_write, rsp_error,
      input  rsp_ready,
      output cpu_re, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata, ready
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      input  cmd_ready,
      input  rsp_valid, rsp_rdata, rsp_write, rsp_error,
      output rsp_ready,
      input  cpu_re, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata, ready
   );
endinterface

// File: rtl/cpu_req_master.sv
// CPU-side initiator: queues host commands, issues them one at a time to the cache
// controller, collects results into a response queue and times out stuck requests.
module cpu_req_master #(
   parameter int ADDRESSLENGTH  = 16,
   parameter int DATALENGTH     = 32,
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT        = 15,
   parameter int RECOVER_CYCLES = 4
) (
   input  logic             clk,
   input  logic             reset,
   cpu_req_master_if.master bus,
   output logic             busy,
   output logic [15:0]      txn_count,
   output logic [7:0]       timeout_count
);

   localparam int PW   = $clog2(FIFO_DEPTH);
   localparam int TMAX = (TIMEOUT > RECOVER_CYCLES) ? TIMEOUT : RECOVER_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);

   localparam logic [TW-1:0] TIMER_LAST   = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] RECOVER_LAST = TW'(RECOVER_CYCLES - 1);
   localparam logic [PW:0]   RSP_ROOM     = (PW + 1)'(FIFO_DEPTH - 1);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] REQ     = 2'd1;
   localparam logic [1:0] RECOVER = 2'd2;

   typedef struct packed {
      logic                     write;
      logic [ADDRESSLENGTH-1:0] addr;
      logic [DATALENGTH-1:0]    wdata;
   } cmd_t;

   typedef struct packed {
      logic [DATALENGTH-1:0] rdata;
      logic                  write;
      logic                  error;
   } rsp_t;

   cmd_t cmd_mem [FIFO_DEPTH];
   rsp_t rsp_mem [FIFO_DEPTH];

   logic [PW:0] cmd_wp, cmd_rp, rsp_wp, rsp_rp, rsp_level;
   logic        cmd_full, cmd_empty, cmd_push, cmd_pop;
   logic        rsp_full, rsp_empty, rsp_push, rsp_pop;
   cmd_t        cmd_head;
   rsp_t        rsp_head, rsp_in;

   logic [1:0]               state;
   logic                     req_write;
   logic [ADDRESSLENGTH-1:0] req_addr;
   logic [DATALENGTH-1:0]    req_wdata;
   logic [TW-1:0]            timer;
   logic                     timed_out;

   assign cmd_empty = (cmd_wp == cmd_rp);
   assign cmd_full  = (cmd_wp[PW] != cmd_rp[PW]) && (cmd_wp[PW-1:0] == cmd_rp[PW-1:0]);
   assign rsp_empty = (rsp_wp == rsp_rp);
   assign rsp_full  = (rsp_wp[PW] != rsp_rp[PW]) && (rsp_wp[PW-1:0] == rsp_rp[PW-1:0]);
   assign rsp_level = rsp_wp - rsp_rp;

   assign cmd_push = bus.cmd_valid && !cmd_full;
   assign rsp_pop  = !rsp_empty && bus.rsp_ready;
   assign cmd_head = cmd_mem[cmd_rp[PW-1:0]];
   assign rsp_head = rsp_mem[rsp_rp[PW-1:0]];

   assign bus.cmd_ready = !cmd_full;
   assign bus.rsp_valid = !rsp_empty;
   assign bus.rsp_rdata = rsp_head.rdata;
   assign bus.rsp_write = rsp_head.write;
   assign bus.rsp_error = rsp_head.error;

   // Gating by ready keeps the controller from seeing a second request in its ready cycle.
   assign bus.cpu_re    = (state == REQ) && !req_write && !bus.ready;
   assign bus.cpu_we    = (state == REQ) &&  req_write && !bus.ready;
   assign bus.cpu_addr  = req_addr;
   assign bus.cpu_wdata = req_wdata;
   assign busy          = (state != IDLE) || !cmd_empty;

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      rsp_push  = 1'b0;
      rsp_in    = '0;
      cmd_pop   = 1'b0;
      timed_out = (state == REQ) && !bus.ready && (timer == TIMER_LAST);
      if ((state == REQ) && (bus.ready || timed_out)) begin
         rsp_push     = 1'b1;
         rsp_in.write = req_write;
         rsp_in.error = timed_out;
         rsp_in.rdata = (bus.ready && !req_write) ? bus.cpu_rdata : '0;
      end
      // Chaining straight out of the ready cycle needs room for this response and the next.
      if (!cmd_empty) begin
         if (state == IDLE)
            cmd_pop = !rsp_full;
         else if ((state == REQ) && bus.ready)
            cmd_pop = (rsp_level < RSP_ROOM) || rsp_pop;
      end
   end

   // NOTE: storage arrays have no reset; the pointers alone decide which entries are live.
   always_ff @(posedge clk) begin
      if (cmd_push)
         cmd_mem[cmd_wp[PW-1:0]] <= '{write: bus.cmd_write, addr: bus.cmd_addr, wdata: bus.cmd_wdata};
      if (rsp_push)
         rsp_mem[rsp_wp[PW-1:0]] <= rsp_in;
   end

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cmd_wp <= '0;
         cmd_rp <= '0;
         rsp_wp <= '0;
         rsp_rp <= '0;
      end else begin
         if (cmd_push) cmd_wp <= cmd_wp + 1'b1;
         if (cmd_pop)  cmd_rp <= cmd_rp + 1'b1;
         if (rsp_push) rsp_wp <= rsp_wp + 1'b1;
         if (rsp_pop)  rsp_rp <= rsp_rp + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         req_write     <= 1'b0;
         req_addr      <= '0;
         req_wdata     <= '0;
         timer         <= '0;
         txn_count     <= '0;
         timeout_count <= '0;
      end else begin
         if (cmd_pop) begin
            req_write <= cmd_head.write;
            req_addr  <= cmd_head.addr;
            req_wdata <= cmd_head.wdata;
         end
         case (state)
            IDLE: begin
               if (cmd_pop) begin
                  state <= REQ;
                  timer <= '0;
               end
            end
            REQ: begin
               if (bus.ready) begin
                  txn_count <= txn_count + 16'd1;
                  timer     <= '0;
                  if (!cmd_pop) state <= IDLE;
               end else if (timed_out) begin
                  txn_count <= txn_count + 16'd1;
                  if (timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
                  timer <= '0;
                  state <= RECOVER;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            RECOVER: begin
               if (timer == RECOVER_LAST) begin
                  timer <= '0;
                  state <= IDLE;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_req_master.sv
// Bench for cpu_req_master: a behavioural cache-controller responder plus a response
// scoreboard, driven by directed scenarios and a randomized command stream.
module tb_cpu_req_master;

   localparam int AL      = 16;
   localparam int DL      = 32;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 15;
   localparam int RECOVER = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        busy;
   logic [15:0] txn_count;
   logic [7:0]  timeout_count;

   cpu_req_master_if #(.ADDRESSLENGTH(AL), .DATALENGTH(DL)) bus ();

   cpu_req_master #(
      .ADDRESSLENGTH(AL), .DATALENGTH(DL), .FIFO_DEPTH(DEPTH),
      .TIMEOUT(TIMEOUT), .RECOVER_CYCLES(RECOVER)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus), .busy(busy),
      .txn_count(txn_count), .timeout_count(timeout_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          write;
      logic [AL-1:0] addr;
      logic [DL-1:0] wdata;
   } cmd_s;

   typedef struct packed {
      logic [DL-1:0] rdata;
      logic          write;
      logic          error;
   } rsp_s;

   cmd_s          cmd_q[$];
   rsp_s          exp_q[$];
   int            lat_q[$];
   logic [DL-1:0] rd_q[$];
   int            txn_start[$];
   int            txn_len[$];

   int n_checks  = 0;
   int n_fail    = 0;
   int cyc       = 0;
   int exp_txn   = 0;
   int exp_to    = 0;
   int rsp_mode  = 0;
   int stray_cyc = -1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Host-side response acceptance: held low, held high, or random.
   initial begin
      bus.rsp_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rsp_mode)
            0:       bus.rsp_ready = 1'b0;
            1:       bus.rsp_ready = 1'b1;
            default: bus.rsp_ready = ($urandom_range(0, 9) < 7);
         endcase
      end
   end

   // Cache-controller model: answers each request after a chosen latency (0 = never).
   initial begin
      bit            active, req, vis_chk, rec_stray;
      int            n, lat;
      cmd_s          c;
      rsp_s          r;
      logic [DL-1:0] rd;
      active = 0; vis_chk = 0; rec_stray = 0; n = 0; lat = 0; rd = '0;
      c = '{1'b0, '0, '0};
      bus.ready = 1'b0;
      bus.cpu_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (active && lat > 0 && n == lat) begin
            bus.ready = 1'b1;
            bus.cpu_rdata = rd;
         end else if (!active && (rec_stray || cyc == stray_cyc)) begin
            bus.ready = 1'b1;
            bus.cpu_rdata = $urandom;
            rec_stray = 0;
         end else begin
            bus.ready = 1'b0;
            bus.cpu_rdata = $urandom;
         end
         @(negedge clk);
         if (!reset) begin
            active = 0;
            vis_chk = 0;
            continue;
         end
         if (vis_chk) begin
            check("rsp_visible_after_ready", bus.rsp_valid, 1);
            vis_chk = 0;
         end
         req = bus.cpu_re | bus.cpu_we;
         if (req) check("re_we_exclusive", bus.cpu_re & bus.cpu_we, 0);
         if (active) begin
            if (bus.ready) begin
               check("req_low_in_ready_cycle", req, 0);
               exp_txn++;
               txn_len.push_back(n);
               active = 0;
               vis_chk = 1;
            end else if (req) begin
               check("req_kind_stable", bus.cpu_we, c.write);
               check("addr_stable", bus.cpu_addr, c.addr);
               if (c.write) check("wdata_stable", bus.cpu_wdata, c.wdata);
               n++;
            end else begin
               check("req_dropped_without_ready", lat == 0, 1);
               check("timeout_len", n, TIMEOUT);
               check("rsp_visible_after_timeout", bus.rsp_valid, 1);
               exp_txn++;
               exp_to++;
               txn_len.push_back(n);
               active = 0;
               rec_stray = 1;
            end
         end
         if (!active && req && !bus.ready) begin
            if (cmd_q.size() == 0) begin
               check("issue_without_cmd", cmd_q.size(), 1);
            end else begin
               c = cmd_q.pop_front();
               check("req_kind", bus.cpu_we, c.write);
               check("req_addr", bus.cpu_addr, c.addr);
               if (c.write) check("req_wdata", bus.cpu_wdata, c.wdata);
               lat = (lat_q.size() > 0) ? lat_q.pop_front() : int'($urandom_range(1, 6));
               rd  = (rd_q.size() > 0) ? rd_q.pop_front() : DL'($urandom);
               r.write = c.write;
               r.error = (lat == 0);
               r.rdata = (lat != 0 && !c.write) ? rd : '0;
               exp_q.push_back(r);
               txn_start.push_back(cyc);
               n = 1;
               active = 1;
            end
         end
      end
   end

   // Scoreboard monitor: every accepted response is compared against the expected queue.
   initial begin
      rsp_s r;
      forever begin
         @(negedge clk);
         if (reset && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_rsp", bus.rsp_valid, 0);
            end else begin
               r = exp_q.pop_front();
               check("rsp", {bus.rsp_rdata, bus.rsp_write, bus.rsp_error}, r);
            end
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic w, input logic [AL-1:0] a, input logic [DL-1:0] d);
      bit ok = 0;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = w;
      bus.cmd_addr  = a;
      bus.cmd_wdata = d;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (bus.cmd_ready) begin
            ok = 1;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (ok) begin
         cmd_q.push_back('{w, a, d});
         @(posedge clk);
         #1;
      end else begin
         check("cmd_accept_timeout", bus.cmd_ready, 1);
      end
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      bit done = 0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (!busy && exp_q.size() == 0 && !bus.rsp_valid) begin
            done = 1;
            break;
         end
      end
      check({tag, "_drained"}, done, 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, %0d checks so far", n_checks);
      $fatal(1, "global timeout");
   end

   initial begin
      int base, started, gap;
      reset = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;

      // Reset state
      #1;
      check("reset_cpu_re", bus.cpu_re, 0);
      check("reset_cpu_we", bus.cpu_we, 0);
      check("reset_cpu_addr", bus.cpu_addr, 0);
      check("reset_cpu_wdata", bus.cpu_wdata, 0);
      check("reset_txn_count", txn_count, 0);
      check("reset_timeout_count", timeout_count, 0);
      check("reset_busy", busy, 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      cycles(1);
      check("release_cmd_ready", bus.cmd_ready, 1);
      check("release_rsp_valid", bus.rsp_valid, 0);

      // Single read, hit latency
      rsp_mode = 1;
      lat_q.push_back(2);
      rd_q.push_back(32'hDEADBEEF);
      send_cmd(1'b0, 16'h0010, 32'h0);
      wait_done("single_read");
      check("single_read_req_cycles", txn_len[0], 2);
      check("single_read_txn_count", txn_count, 16'(exp_txn));

      // Write then read-miss back to back
      lat_q.push_back(2);
      lat_q.push_back(4);
      send_cmd(1'b1, 16'h0040, 32'h0000_1234);
      send_cmd(1'b0, 16'h0040, 32'h0);
      wait_done("wr_rd");
      base = txn_start.size() - 2;
      gap = txn_start[base + 1] - (txn_start[base] + txn_len[base]);
      check("back_to_back_gap", gap, 1);
      check("read_miss_req_cycles", txn_len[base + 1], 4);
      check("wr_rd_txn_count", txn_count, 16'(exp_txn));

      // Response FIFO full stalls issue; command FIFO then fills
      rsp_mode = 0;
      base = txn_start.size();
      for (int i = 0; i < 8; i++) begin
         lat_q.push_back(2);
         send_cmd(1'($urandom_range(0, 1)), 16'($urandom), 32'($urandom));
      end
      cycles(20);
      started = txn_start.size() - base;
      check("full_cmd_ready_low", bus.cmd_ready, 0);
      check("full_issued_count", started, DEPTH);
      check("full_rsp_valid", bus.rsp_valid, 1);
      check("full_busy", busy, 1);
      @(negedge clk) rsp_mode = 1;
      @(negedge clk) rsp_mode = 0;
      cycles(10);
      started = txn_start.size() - base;
      check("after_pop_issued_count", started, DEPTH + 1);
      check("after_pop_cmd_ready", bus.cmd_ready, 1);
      @(negedge clk) rsp_mode = 1;
      cycles(1);
      wait_done("fifo_full");
      check("fifo_full_txn_count", txn_count, 16'(exp_txn));

      // Timeout, recovery (with a ready pulse during recovery), then a normal command
      lat_q.push_back(0);
      lat_q.push_back(2);
      send_cmd(1'b0, 16'h0100, 32'h0);
      send_cmd(1'b1, 16'h0104, 32'hCAFE_F00D);
      wait_done("timeout");
      base = txn_start.size() - 2;
      gap = txn_start[base + 1] - (txn_start[base] + txn_len[base]);
      check("timeout_req_cycles", txn_len[base], TIMEOUT);
      check("recover_gap", (gap >= RECOVER) && (gap <= RECOVER + 1), 1);
      check("timeout_count", timeout_count, 8'(exp_to));
      check("timeout_txn_count", txn_count, 16'(exp_txn));

      // Stray ready while idle
      stray_cyc = cyc + 2;
      cycles(6);
      check("stray_txn_count", txn_count, 16'(exp_txn));
      check("stray_rsp_valid", bus.rsp_valid, 0);
      check("stray_busy", busy, 0);

      // Randomized traffic
      rsp_mode = 2;
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 19) == 0) lat_q.push_back(0);
         else lat_q.push_back(int'($urandom_range(1, 6)));
         if ($urandom_range(0, 3) == 0) cycles(int'($urandom_range(1, 5)));
         send_cmd(1'($urandom_range(0, 1)), 16'($urandom), 32'($urandom));
      end
      @(negedge clk) rsp_mode = 1;
      cycles(1);
      wait_done("random");
      check("random_txn_count", txn_count, 16'(exp_txn));
      check("random_timeout_count", timeout_count, 8'((exp_to > 255) ? 255 : exp_to));

      // Reset in the middle of a request
      lat_q.push_back(0);
      send_cmd(1'b0, 16'h0200, 32'h0);
      cycles(3);
      check("pre_reset_cpu_re", bus.cpu_re, 1);
      #2;
      reset = 1'b0;
      #1;
      check("async_reset_cpu_re", bus.cpu_re, 0);
      check("async_reset_cpu_we", bus.cpu_we, 0);
      check("async_reset_cpu_addr", bus.cpu_addr, 0);
      check("async_reset_rsp_valid", bus.rsp_valid, 0);
      check("async_reset_busy", busy, 0);
      check("async_reset_txn_count", txn_count, 0);
      check("async_reset_timeout_count", timeout_count, 0);
      cmd_q.delete();
      exp_q.delete();
      lat_q.delete();
      rd_q.delete();
      exp_txn = 0;
      exp_to = 0;
      base = txn_start.size();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      cycles(20);
      check("post_reset_rsp_valid", bus.rsp_valid, 0);
      check("post_reset_cmd_ready", bus.cmd_ready, 1);
      check("post_reset_no_request", txn_start.size() - base, 0);
      check("post_reset_txn_count", txn_count, 16'(exp_txn));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
